// File: rtl/serial_add_sub.sv
// ============================================================================
// Module   : serial_add_sub
// Brief    : Bit-serial adder/subtractor, one bit per clock, LSB first.
//            Optional signed-overflow output guarded by SERIAL_ADD_SUB_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_add_sub #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_start,
    input  logic             io_op,
    input  logic [WIDTH-1:0] io_a,
    input  logic [WIDTH-1:0] io_b,
    output logic             io_busy,
    output logic             io_done,
    output logic [WIDTH-1:0] io_result,
    output logic             io_cout
`ifdef SERIAL_ADD_SUB_OVF_EN
    ,
    output logic             io_ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_shift_a;
    logic [WIDTH-1:0]   r_shift_b;
    logic [WIDTH-1:0]   r_shift_r;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_sum;
    logic               w_carry_nxt;
    logic               w_last;

    // Single full-adder slice shared by every bit position
    assign w_sum       = r_shift_a[0] ^ r_shift_b[0] ^ r_carry;
    assign w_carry_nxt = (r_shift_a[0] & r_shift_b[0]) |
                         (r_shift_a[0] & r_carry) |
                         (r_shift_b[0] & r_carry);
    assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));

    assign io_busy = (r_state == S_RUN);
    assign io_done = (r_state == S_DONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (io_start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last)   w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shift_a <= '0;
            r_shift_b <= '0;
            r_shift_r <= '0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            io_result <= '0;
            io_cout   <= 1'b0;
        end else begin
            if (r_state == S_IDLE && io_start) begin
                // Subtraction is a + ~b + 1: invert b and seed the carry with 1
                r_shift_a <= io_a;
                r_shift_b <= io_op ? ~io_b : io_b;
                r_carry   <= io_op;
                r_cnt     <= '0;
            end else if (r_state == S_RUN) begin
                r_shift_a <= {1'b0, r_shift_a[WIDTH-1:1]};
                r_shift_b <= {1'b0, r_shift_b[WIDTH-1:1]};
                r_shift_r <= {w_sum, r_shift_r[WIDTH-1:1]};
                r_carry   <= w_carry_nxt;
                r_cnt     <= r_cnt + 1'b1;
                if (w_last) begin
                    io_result <= {w_sum, r_shift_r[WIDTH-1:1]};
                    io_cout   <= w_carry_nxt;
                end
            end
        end
    end

`ifdef SERIAL_ADD_SUB_OVF_EN
    // In the final RUN cycle r_carry is the carry into the MSB
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_ovf <= 1'b0;
        end else if (r_state == S_RUN && w_last) begin
            io_ovf <= r_carry ^ w_carry_nxt;
        end
    end
`endif

endmodule

`default_nettype wire
